// File: rtl/mem_port_arbiter.sv
// Shares one OBI-style memory port between instruction fetch and load/store, one outstanding transaction.
// Define MEM_ARB_FAIR_EN to add the fetch anti-starvation counter (STARVE_LIMIT consecutive data grants).
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  instr_req_i,
  input  logic [ADDR_WIDTH-1:0] instr_addr_i,
  input  logic                  instr_kill_i,
  output logic                  instr_gnt_o,
  output logic                  instr_rvalid_o,
  output logic [31:0]           instr_rdata_o,
  input  logic                  data_req_i,
  input  logic                  data_we_i,
  input  logic [3:0]            data_be_i,
  input  logic [ADDR_WIDTH-1:0] data_addr_i,
  input  logic [31:0]           data_wdata_i,
  output logic                  data_gnt_o,
  output logic                  data_rvalid_o,
  output logic [31:0]           data_rdata_o,
  output logic                  bus_req_o,
  output logic                  bus_we_o,
  output logic [3:0]            bus_be_o,
  output logic [ADDR_WIDTH-1:0] bus_addr_o,
  output logic [31:0]           bus_wdata_o,
  input  logic                  bus_gnt_i,
  input  logic                  bus_rvalid_i,
  input  logic [31:0]           bus_rdata_i,
  output logic                  protocol_err_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic {
    OWN_INSTR = 1'b0,
    OWN_DATA  = 1'b1
  } owner_e;

  state_e state_q, state_d;
  owner_e owner_q, owner_d, sel_owner_s;
  logic   drop_q, drop_d;
  logic   perr_q, perr_d;
  logic   rsp_s, free_s, issue_s, prefer_instr_s;
  logic   instr_gnt_s, data_gnt_s;

`ifdef MEM_ARB_FAIR_EN
  logic [3:0] starve_q, starve_d;
  assign prefer_instr_s = (starve_q == 4'(STARVE_LIMIT)) && instr_req_i && !instr_kill_i;
`else
  assign prefer_instr_s = 1'b0;
`endif

  // A response in RESP frees the slot so the next request can issue back-to-back.
  assign rsp_s  = (state_q == ST_RESP) && bus_rvalid_i;
  assign free_s = (state_q == ST_IDLE) || rsp_s;

  // Requester selection: locked owner in ADDR, otherwise data first (fetch blocked while killed).
  always_comb begin
    sel_owner_s = owner_q;
    issue_s     = 1'b0;
    if (state_q == ST_ADDR) begin
      issue_s = 1'b1;
    end else if (free_s) begin
      if (data_req_i && !prefer_instr_s) begin
        sel_owner_s = OWN_DATA;
        issue_s     = 1'b1;
      end else if (instr_req_i && !instr_kill_i) begin
        sel_owner_s = OWN_INSTR;
        issue_s     = 1'b1;
      end else begin
        issue_s = 1'b0;
      end
    end else begin
      issue_s = 1'b0;
    end
  end

  assign instr_gnt_s = issue_s && bus_gnt_i && (sel_owner_s == OWN_INSTR);
  assign data_gnt_s  = issue_s && bus_gnt_i && (sel_owner_s == OWN_DATA);

  assign bus_req_o   = rst_n_i && issue_s;
  assign bus_we_o    = (sel_owner_s == OWN_DATA) ? data_we_i : 1'b0;
  assign bus_be_o    = (sel_owner_s == OWN_DATA) ? data_be_i : 4'hF;
  assign bus_addr_o  = (sel_owner_s == OWN_DATA) ? data_addr_i : instr_addr_i;
  assign bus_wdata_o = (sel_owner_s == OWN_DATA) ? data_wdata_i : 32'h0000_0000;

  assign instr_gnt_o    = rst_n_i && instr_gnt_s;
  assign data_gnt_o     = rst_n_i && data_gnt_s;
  assign instr_rvalid_o = rst_n_i && rsp_s && (owner_q == OWN_INSTR) && !drop_q && !instr_kill_i;
  assign data_rvalid_o  = rst_n_i && rsp_s && (owner_q == OWN_DATA);
  assign instr_rdata_o  = bus_rdata_i;
  assign data_rdata_o   = bus_rdata_i;
  assign protocol_err_o = perr_q;

  // Next state, owner latch, stale-fetch drop flag and sticky protocol error.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    drop_d  = drop_q;
    perr_d  = perr_q;
    case (state_q)
      ST_IDLE, ST_RESP: begin
        if (issue_s) begin
          owner_d = sel_owner_s;
          state_d = bus_gnt_i ? ST_RESP : ST_ADDR;
        end else if (free_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = state_q;
        end
      end
      ST_ADDR: begin
        if (bus_gnt_i) begin
          state_d = ST_RESP;
        end else begin
          state_d = ST_ADDR;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // A kill in ADDR also covers a fetch granted in that same cycle.
    if (rsp_s) begin
      drop_d = 1'b0;
    end else if (instr_kill_i && (owner_q == OWN_INSTR) &&
                 ((state_q == ST_ADDR) || (state_q == ST_RESP))) begin
      drop_d = 1'b1;
    end else begin
      drop_d = drop_q;
    end
    if (bus_rvalid_i && (state_q != ST_RESP)) begin
      perr_d = 1'b1;
    end else begin
      perr_d = perr_q;
    end
  end

  // Arbiter state registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_INSTR;
      drop_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      drop_q  <= drop_d;
      perr_q  <= perr_d;
    end
  end

`ifdef MEM_ARB_FAIR_EN
  // Count data grants that bypass a waiting fetch; saturate rather than wrap.
  always_comb begin
    starve_d = starve_q;
    if (!instr_req_i || instr_gnt_s) begin
      starve_d = 4'd0;
    end else if (data_gnt_s && !instr_kill_i && (starve_q != 4'hF)) begin
      starve_d = starve_q + 4'd1;
    end else begin
      starve_d = starve_q;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      starve_q <= 4'd0;
    end else begin
      starve_q <= starve_d;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: cycle-driven bus stimulus with a response scoreboard.
module tb_mem_port_arbiter;

`ifdef MEM_ARB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        instr_req_i, instr_kill_i, data_req_i, data_we_i;
  logic [31:0] instr_addr_i, data_addr_i, data_wdata_i, bus_rdata_i;
  logic [3:0]  data_be_i;
  logic        bus_gnt_i, bus_rvalid_i;
  logic        instr_gnt_o, instr_rvalid_o, data_gnt_o, data_rvalid_o;
  logic [31:0] instr_rdata_o, data_rdata_o, bus_addr_o, bus_wdata_o;
  logic        bus_req_o, bus_we_o, protocol_err_o;
  logic [3:0]  bus_be_o;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [33:0] exp_q[$];               // {dropped, is_instr, rdata}
  logic [31:0] seq_data = 32'hA500_0001;
  logic [33:0] e;

  mem_port_arbiter #(.ADDR_WIDTH(32), .STARVE_LIMIT(4)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_kill_i(instr_kill_i),
    .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o),
    .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
    .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
    .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_be_o(bus_be_o),
    .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
    .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i),
    .protocol_err_o(protocol_err_o)
  );

  always #5 clk_i = ~clk_i;

  // Drive one cycle of inputs just after the rising edge; return at the falling edge for sampling.
  task automatic drive(input logic ireq, input logic [31:0] iaddr, input logic kill,
                       input logic dreq, input logic [31:0] daddr, input logic gnt, input logic rv);
    @(posedge clk_i);
    #1;
    instr_req_i  = ireq;
    instr_addr_i = iaddr;
    instr_kill_i = kill;
    data_req_i   = dreq;
    data_addr_i  = daddr;
    bus_gnt_i    = gnt;
    bus_rvalid_i = rv;
    bus_rdata_i  = (rv && exp_q.size() > 0) ? exp_q[0][31:0] : 32'h0BAD_0BAD;
    @(negedge clk_i);
  endtask

  task automatic push(input logic is_instr, input logic dropped);
    exp_q.push_back({dropped, is_instr, seq_data});
    seq_data = seq_data + 32'h0101_0101;
  endtask

  function automatic logic [33:0] resp_exp(input logic [33:0] x);
    return {~x[33] & x[32], ~x[32], x[31:0]};
  endfunction

  function automatic logic [33:0] resp_got(input logic is_instr);
    return {instr_rvalid_o, data_rvalid_o, is_instr ? instr_rdata_o : data_rdata_o};
  endfunction

  task automatic test_reset();
    rst_n_i = 1'b0;
    instr_req_i = 1'b1; instr_addr_i = 32'h0; instr_kill_i = 1'b0;
    data_req_i = 1'b1; data_we_i = 1'b0; data_be_i = 4'hF; data_addr_i = 32'h0; data_wdata_i = 32'h0;
    bus_gnt_i = 1'b1; bus_rvalid_i = 1'b1; bus_rdata_i = 32'h0;
    #8;
    n_checks++;
    if ({bus_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o, protocol_err_o} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b exp 000000",
               {bus_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o, protocol_err_o});
    end
    instr_req_i = 1'b0; data_req_i = 1'b0; bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0;
    #4;
    rst_n_i = 1'b1;
  endtask

  task automatic test_alternation();
    drive(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    n_checks++;
    if ({bus_req_o, bus_addr_o, instr_gnt_o, data_gnt_o} !== {1'b1, 32'h100, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL alt_fetch0: got %h exp %h", {bus_req_o, bus_addr_o, instr_gnt_o, data_gnt_o}, {1'b1, 32'h100, 1'b1, 1'b0});
    end
    push(1'b1, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h2000, 1'b1, 1'b1);
    e = exp_q.pop_front(); n_checks++;
    if (resp_got(e[32]) !== resp_exp(e)) begin
      n_fail++; $display("FAIL alt_resp0: got %h exp %h", resp_got(e[32]), resp_exp(e));
    end
    n_checks++;
    if ({bus_addr_o, bus_we_o, data_gnt_o, instr_gnt_o} !== {32'h2000, 1'b0, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL alt_load: got %h exp %h", {bus_addr_o, bus_we_o, data_gnt_o, instr_gnt_o}, {32'h2000, 1'b0, 1'b1, 1'b0});
    end
    push(1'b0, 1'b0);
    drive(1'b1, 32'h104, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    e = exp_q.pop_front(); n_checks++;
    if (resp_got(e[32]) !== resp_exp(e)) begin
      n_fail++; $display("FAIL alt_resp1: got %h exp %h", resp_got(e[32]), resp_exp(e));
    end
    n_checks++;
    if ({bus_addr_o, instr_gnt_o, data_gnt_o} !== {32'h104, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL alt_fetch1: got %h exp %h", {bus_addr_o, instr_gnt_o, data_gnt_o}, {32'h104, 1'b1, 1'b0});
    end
    push(1'b1, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    e = exp_q.pop_front(); n_checks++;
    if (resp_got(e[32]) !== resp_exp(e)) begin
      n_fail++; $display("FAIL alt_resp2: got %h exp %h", resp_got(e[32]), resp_exp(e));
    end
    n_checks++;
    if (bus_req_o !== 1'b0) begin
      n_fail++; $display("FAIL alt_idle: got bus_req_o=%b exp 0", bus_req_o);
    end
  endtask

  task automatic test_simultaneous();
    data_we_i = 1'b1; data_be_i = 4'h3; data_wdata_i = 32'h1234_5678;
    drive(1'b1, 32'h200, 1'b0, 1'b1, 32'h3000, 1'b1, 1'b0);
    n_checks++;
    if ({bus_addr_o, bus_we_o, bus_be_o, bus_wdata_o, data_gnt_o, instr_gnt_o} !==
        {32'h3000, 1'b1, 4'h3, 32'h1234_5678, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL sim_data_first: got %h exp %h",
        {bus_addr_o, bus_we_o, bus_be_o, bus_wdata_o, data_gnt_o, instr_gnt_o},
        {32'h3000, 1'b1, 4'h3, 32'h1234_5678, 1'b1, 1'b0});
    end
    push(1'b0, 1'b0);
    data_we_i = 1'b0; data_be_i = 4'hF; data_wdata_i = 32'h0;
    drive(1'b1, 32'h200, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    e = exp_q.pop_front(); n_checks++;
    if (resp_got(e[32]) !== resp_exp(e)) begin
      n_fail++; $display("FAIL sim_store_resp: got %h exp %h", resp_got(e[32]), resp_exp(e));
    end
    n_checks++;
    if ({bus_addr_o, instr_gnt_o, data_gnt_o} !== {32'h200, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL sim_fetch_next: got %h exp %h", {bus_addr_o, instr_gnt_o, data_gnt_o}, {32'h200, 1'b1, 1'b0});
    end
    push(1'b1, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    e = exp_q.pop_front(); n_checks++;
    if (resp_got(e[32]) !== resp_exp(e)) begin
      n_fail++; $display("FAIL sim_fetch_resp: got %h exp %h", resp_got(e[32]), resp_exp(e));
    end
  endtask

  task automatic test_wait_states();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h300, 1'b0, (i > 0), 32'h4000, (i == 3), 1'b0);
      n_checks++;
      if ({bus_req_o, bus_addr_o, instr_gnt_o, data_gnt_o} !== {1'b1, 32'h300, (i == 3), 1'b0}) begin
        n_fail++; $display("FAIL wait_cycle%0d: got %h exp %h", i,
          {bus_req_o, bus_addr_o, instr_gnt_o, data_gnt_o}, {1'b1, 32'h300, (i == 3), 1'b0});
      end
    end
    push(1'b1, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h4000, 1'b1, 1'b1);
    e = exp_q.pop_front(); n_checks++;
    if (resp_got(e[32]) !== resp_exp(e)) begin
      n_fail++; $display("FAIL wait_fetch_resp: got %h exp %h", resp_got(e[32]), resp_exp(e));
    end
    n_checks++;
    if ({bus_addr_o, data_gnt_o, instr_gnt_o} !== {32'h4000, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL wait_data_follows: got %h exp %h", {bus_addr_o, data_gnt_o, instr_gnt_o}, {32'h4000, 1'b1, 1'b0});
    end
    push(1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    e = exp_q.pop_front(); n_checks++;
    if (resp_got(e[32]) !== resp_exp(e)) begin
      n_fail++; $display("FAIL wait_data_resp: got %h exp %h", resp_got(e[32]), resp_exp(e));
    end
  endtask

  task automatic test_kill();
    drive(1'b1, 32'h400, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    exp_q.push_back({1'b1, 1'b1, 32'hDEAD_BEEF});
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    n_checks++;
    if ({instr_rvalid_o, bus_req_o} !== 2'b00) begin
      n_fail++; $display("FAIL kill_pulse: got %b exp 00", {instr_rvalid_o, bus_req_o});
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    drive(1'b1, 32'h408, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    e = exp_q.pop_front(); n_checks++;
    if (resp_got(e[32]) !== resp_exp(e)) begin
      n_fail++; $display("FAIL kill_dropped: got %h exp %h", resp_got(e[32]), resp_exp(e));
    end
    n_checks++;
    if ({instr_gnt_o, bus_addr_o} !== {1'b1, 32'h408}) begin
      n_fail++; $display("FAIL kill_refetch: got %h exp %h", {instr_gnt_o, bus_addr_o}, {1'b1, 32'h408});
    end
    push(1'b1, 1'b0);
    drive(1'b1, 32'h500, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    e = exp_q.pop_front(); n_checks++;
    if (resp_got(e[32]) !== resp_exp(e)) begin
      n_fail++; $display("FAIL kill_next_ok: got %h exp %h", resp_got(e[32]), resp_exp(e));
    end
    push(1'b1, 1'b1);
    drive(1'b1, 32'h504, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    e = exp_q.pop_front(); n_checks++;
    if (resp_got(e[32]) !== resp_exp(e)) begin
      n_fail++; $display("FAIL kill_same_cycle: got %h exp %h", resp_got(e[32]), resp_exp(e));
    end
    n_checks++;
    if (bus_req_o !== 1'b0) begin
      n_fail++; $display("FAIL kill_blocks_fetch: got bus_req_o=%b exp 0", bus_req_o);
    end
  endtask

  task automatic test_protocol_err();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    n_checks++;
    if ({instr_rvalid_o, data_rvalid_o, protocol_err_o} !== 3'b000) begin
      n_fail++; $display("FAIL perr_not_forwarded: got %b exp 000", {instr_rvalid_o, data_rvalid_o, protocol_err_o});
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    n_checks++;
    if (protocol_err_o !== 1'b1) begin
      n_fail++; $display("FAIL perr_set: got %b exp 1", protocol_err_o);
    end
    drive(1'b1, 32'h700, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    drive(1'b1, 32'h700, 1'b0, 1'b1, 32'h800, 1'b0, 1'b0);
    n_checks++;
    if ({bus_req_o, bus_addr_o, protocol_err_o} !== {1'b1, 32'h700, 1'b1}) begin
      n_fail++; $display("FAIL perr_sticky_addr: got %h exp %h", {bus_req_o, bus_addr_o, protocol_err_o}, {1'b1, 32'h700, 1'b1});
    end
    #2;
    rst_n_i = 1'b0; bus_gnt_i = 1'b1; bus_rvalid_i = 1'b1;
    #1;
    n_checks++;
    if ({bus_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o, protocol_err_o} !== 6'b0) begin
      n_fail++; $display("FAIL reset_mid_addr: got %b exp 000000",
        {bus_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o, protocol_err_o});
    end
    instr_req_i = 1'b0; data_req_i = 1'b0; bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0;
    rst_n_i = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    n_checks++;
    if ({bus_req_o, protocol_err_o} !== 2'b00) begin
      n_fail++; $display("FAIL reset_idle: got %b exp 00", {bus_req_o, protocol_err_o});
    end
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h900, 1'b1, 1'b0);
    n_checks++;
    if ({data_gnt_o, bus_addr_o} !== {1'b1, 32'h900}) begin
      n_fail++; $display("FAIL reset_then_load: got %h exp %h", {data_gnt_o, bus_addr_o}, {1'b1, 32'h900});
    end
    push(1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    e = exp_q.pop_front(); n_checks++;
    if ({resp_got(e[32]), protocol_err_o} !== {resp_exp(e), 1'b0}) begin
      n_fail++; $display("FAIL reset_then_resp: got %h exp %h", {resp_got(e[32]), protocol_err_o}, {resp_exp(e), 1'b0});
    end
  endtask

  task automatic test_fairness();
    int  cnt_m = 0;
    int  n_igr = 0;
    logic exp_instr;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 32'h600, 1'b0, 1'b1, 32'h5000, 1'b1, (i > 0));
      if (i > 0) begin
        e = exp_q.pop_front(); n_checks++;
        if (resp_got(e[32]) !== resp_exp(e)) begin
          n_fail++; $display("FAIL fair_resp%0d: got %h exp %h", i, resp_got(e[32]), resp_exp(e));
        end
      end
      exp_instr = FAIR && (cnt_m == 4);
      n_checks++;
      if ({instr_gnt_o, data_gnt_o, bus_addr_o} !== {exp_instr, ~exp_instr, exp_instr ? 32'h600 : 32'h5000}) begin
        n_fail++; $display("FAIL fair_grant%0d: got %h exp %h", i, {instr_gnt_o, data_gnt_o, bus_addr_o},
                           {exp_instr, ~exp_instr, exp_instr ? 32'h600 : 32'h5000});
      end
      push(exp_instr, 1'b0);
      cnt_m = exp_instr ? 0 : cnt_m + 1;
      if (instr_gnt_o === 1'b1) n_igr++;
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    e = exp_q.pop_front(); n_checks++;
    if (resp_got(e[32]) !== resp_exp(e)) begin
      n_fail++; $display("FAIL fair_drain: got %h exp %h", resp_got(e[32]), resp_exp(e));
    end
    n_checks++;
    if (n_igr !== (FAIR ? 4 : 0)) begin
      n_fail++; $display("FAIL fair_instr_count: got %0d exp %0d", n_igr, FAIR ? 4 : 0);
    end
  endtask

  initial begin
    test_reset();
    test_alternation();
    test_simultaneous();
    test_wait_states();
    test_kill();
    test_protocol_err();
    test_fairness();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the core's single memory port between instruction fetch (IF) and the load/store path (MEM stage). It uses an OBI-style req/gnt/rvalid handshake and allows at most one outstanding transaction. Data accesses normally win arbitration because they belong to an older instruction. The block sits between the IF/MEM stages and the external bus, and gives the hazard controller a way to discard stale fetches after a flush.

## Interface
- ADDR_WIDTH, 32, address width of all ports.
- STARVE_LIMIT, 4, consecutive data grants with fetch pending before fetch is forced to win (used only with MEM_ARB_FAIR_EN; legal range 1..15).

- clk_i  in  1  core clock.
- rst_n_i  in  1  reset; asynchronous, active-low.
- instr_req_i  in  1  fetch request; held with instr_addr_i until instr_gnt_o.
- instr_addr_i  in  ADDR_WIDTH  fetch address.
- instr_kill_i  in  1  flush from controller; discards current/pending fetch.
- instr_gnt_o  out  1  fetch address accepted.
- instr_rvalid_o  out  1  fetch data valid.
- instr_rdata_o  out  32  fetch data (bus_rdata_i passthrough).
- data_req_i  in  1  load/store request; held with payload until data_gnt_o.
- data_we_i  in  1  store when 1.
- data_be_i  in  4  byte enables.
- data_addr_i  in  ADDR_WIDTH  data address.
- data_wdata_i  in  32  store data.
- data_gnt_o  out  1  data address accepted.
- data_rvalid_o  out  1  data response valid (loads and stores).
- data_rdata_o  out  32  load data (passthrough).
- bus_req_o / bus_we_o / bus_be_o / bus_addr_o / bus_wdata_o  out  1/1/4/ADDR_WIDTH/32  shared port request.
- bus_gnt_i  in  1  bus accepted request.
- bus_rvalid_i  in  1  bus response valid.
- bus_rdata_i  in  32  bus response data.
- protocol_err_o  out  1  sticky; rvalid received with nothing outstanding.

## Operation
- FSM states:
  - IDLE: nothing on the bus.
  - ADDR: bus_req_o held, waiting for gnt; owner is locked.
  - RESP: one transaction outstanding, waiting for rvalid.
- Registers:
  - owner (INSTR/DATA), latched at each grant or lock.
  - drop flag.
  - protocol_err.
  - starve counter (only with the macro).
- Free slot means either of:
  - state IDLE;
  - state RESP with bus_rvalid_i high, so a back-to-back issue is allowed.
- Selection in a free slot:
  - data_req_i wins.
  - Otherwise instr_req_i wins, provided instr_kill_i is low.
  - The selected requester drives bus_* combinationally, with bus_req_o=1.
- After a bus request is issued:
  - bus_gnt_i=1: requester gnt_o=1 this cycle, owner latched, next state RESP.
  - bus_gnt_i=0: next state ADDR with owner locked. The other requester cannot preempt. bus_* keeps following the locked owner's inputs until gnt, then RESP.
- In a free slot with no request, next state IDLE.
- In RESP, bus_rvalid_i routes rvalid/rdata to the owner.
  - instr_rvalid_o is suppressed when drop=1; drop is then cleared.
- instr_kill_i:
  - With owner INSTR in ADDR or RESP, sets drop. The bus transaction still completes because OBI requests cannot be retracted.
  - Kill and rvalid in the same cycle: that response is dropped.
  - A fetch granted in the same cycle as kill is also dropped.
  - Kill has no effect on data transactions.
- bus_rvalid_i while state is IDLE or ADDR: sets protocol_err_o, which is sticky until reset. The response is not forwarded.
- Requesters must not deassert req before gnt. This is not checked.

## Timing
- Grant is 0-cycle: gnt_o is combinational from bus_gnt_i in the same cycle as the request.
- Response is 0-cycle: rvalid_o/rdata_o are combinational from bus_rvalid_i/bus_rdata_i.
- A zero-wait bus sustains one transaction per cycle via the RESP-with-rvalid free slot.
- Minimum request-to-rvalid latency is 1 cycle.
- Reset values, and values held while rst_n_i is low:
  - state IDLE, drop=0, protocol_err_o=0, counter=0.
  - bus_req_o, all gnt_o and all rvalid_o are forced to 0.
- Reset in the middle of a transaction abandons it. A stale rvalid arriving after reset sets protocol_err_o, so memory must be reset together with the core.

## Configuration
- MEM_ARB_FAIR_EN defined:
  - A 4-bit counter increments on each data grant while instr_req_i=1 and instr_kill_i=0.
  - When counter==STARVE_LIMIT, the next free-slot selection prefers instr over data.
  - The counter clears on any instr grant, or whenever instr_req_i=0.
- Not defined:
  - Strict data priority; no counter logic is present.
  - A continuous stream of data requests can starve fetch indefinitely.

## Test plan
- Zero-wait alternation:
  - Stimulus: fetch at 0x100, then load at 0x2000, then fetch at 0x104.
  - Required: three grants in 3 consecutive cycles, each rvalid routed to the correct owner one cycle later with matching rdata.
- Simultaneous requests:
  - Stimulus: fetch and data requested in the same cycle.
  - Required: data granted first (bus_addr_o = data_addr_i), fetch granted in the next free slot.
- Wait states:
  - Stimulus: fetch issued with bus_gnt_i low for 3 cycles, data_req_i rising during the wait.
  - Required: bus_addr_o stays at the fetch address and data_gnt_o=0 until the fetch gnt; the data request follows.
- Kill:
  - Stimulus: fetch outstanding in RESP, instr_kill_i pulsed, rvalid arrives 2 cycles later with 0xDEADBEEF.
  - Required: instr_rvalid_o stays 0, and the next fetch response is delivered normally.
- Protocol error and reset:
  - Stimulus: bus_rvalid_i in IDLE, then an async reset pulsed mid-ADDR.
  - Required: protocol_err_o=1 stays set until reset; after reset all outputs read 0 and state is IDLE.
- Fairness, with MEM_ARB_FAIR_EN and STARVE_LIMIT=4:
  - Stimulus: continuous data_req_i and instr_req_i.
  - Required: the grant pattern is 4 data, 1 instr, repeating. Without the macro, zero instr grants occur.
